// File: rtl/img_streamer_pkg.sv
// Shared types and constants for the image streamer: FSM states and image geometry.
package img_streamer_pkg;

    localparam int unsigned PIXELS_PER_IMAGE = 784;
    localparam int unsigned BITS_PER_BYTE    = 8;
    localparam int unsigned ADDR_W           = $clog2(PIXELS_PER_IMAGE);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSend,
        StTxWait,
        StRxWait,
        StFin
    } state_e;

endpackage

// File: rtl/img_streamer_pixel_packer.sv
// Fetches the 8 pixels of one byte from a 1-cycle-latency bit RAM and packs them LSB-first.
module img_streamer_pixel_packer
    import img_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [6:0]        byte_idx,
    input  logic              img_q,
    output logic [ADDR_W-1:0] img_addr,
    output logic [7:0]        data,
    output logic              ready
);

    logic       active_q;
    logic [2:0] bit_cnt_q;
    logic       cap_en_q;
    logic [2:0] cap_idx_q;
    logic [7:0] data_q;

    localparam logic [2:0] LastBit = 3'(BITS_PER_BYTE - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            bit_cnt_q <= '0;
            cap_en_q  <= 1'b0;
            cap_idx_q <= '0;
            data_q    <= '0;
        end else begin
            if (go) begin
                active_q  <= 1'b1;
                bit_cnt_q <= '0;
                cap_en_q  <= 1'b0;
            end else if (active_q) begin
                // img_q for this address arrives next cycle, so remember which bit it lands in
                cap_en_q  <= 1'b1;
                cap_idx_q <= bit_cnt_q;
                if (bit_cnt_q == LastBit) begin
                    active_q <= 1'b0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else begin
                cap_en_q <= 1'b0;
            end
            if (cap_en_q) begin
                data_q[cap_idx_q] <= img_q;
            end
        end
    end

    assign img_addr = {byte_idx, bit_cnt_q};
    assign data     = data_q;
    // Asserted in the ninth fetch cycle, while bit 7 is being captured
    assign ready    = cap_en_q && (cap_idx_q == LastBit);

endmodule

// File: rtl/img_streamer.sv
// Streams one packed 784-pixel image over a UART transmitter and collects the classifier's reply.
module img_streamer
    import img_streamer_pkg::*;
#(
    parameter int unsigned NUM_BYTES  = 98,
    parameter logic [19:0] RX_TIMEOUT = 20'd1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] img_addr,
    input  logic              img_q,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic [3:0]        expected,
    output logic              busy,
    output logic              done,
    output logic [7:0]        digit,
    output logic              match,
    output logic              timeout
);

    localparam logic [6:0] LastByte = 7'(NUM_BYTES - 1);

    state_e      state_q, state_d;
    logic [6:0]  byte_cnt_q, byte_cnt_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic [3:0]  expected_q, expected_d;
    logic [7:0]  digit_q, digit_d;
    logic        match_q, match_d;
    logic        timeout_q, timeout_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        fetch_go;
    logic        pack_ready;
    logic [7:0]  pack_data;

    img_streamer_pixel_packer pixel_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (fetch_go),
        .byte_idx (byte_cnt_q),
        .img_q    (img_q),
        .img_addr (img_addr),
        .data     (pack_data),
        .ready    (pack_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            expected_q <= '0;
            digit_q    <= 8'h00;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            expected_q <= expected_d;
            digit_q    <= digit_d;
            match_q    <= match_d;
            timeout_q  <= timeout_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        expected_d = expected_q;
        digit_d    = digit_q;
        match_d    = match_q;
        timeout_d  = timeout_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        fetch_go   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFetch;
                    byte_cnt_d = '0;
                    expected_d = expected;
                    fetch_go   = 1'b1;
                end
            end
            StFetch: begin
                if (pack_ready) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_rdy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = pack_data;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                // tx_start_q marks the first cycle here, before the UART can drop tx_rdy
                if (!tx_start_q && tx_rdy) begin
                    if (byte_cnt_q == LastByte) begin
                        state_d  = StRxWait;
                        to_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 7'd1;
                        state_d    = StFetch;
                        fetch_go   = 1'b1;
                    end
                end
            end
            StRxWait: begin
                if (rx_rdy) begin
                    digit_d   = rx_data;
                    match_d   = (rx_data == {4'h0, expected_q});
                    timeout_d = 1'b0;
                    state_d   = StFin;
                end else if (to_cnt_q == RX_TIMEOUT - 20'd1) begin
                    digit_d   = 8'hFF;
                    match_d   = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    to_cnt_d = to_cnt_q + 20'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign digit    = digit_q;
    assign match    = match_q;
    assign timeout  = timeout_q;

endmodule
